// File: rtl/sprite_dma.sv
// Purpose : CPU-programmed DMA that copies len bytes from Z80 memory into object RAM.
// Latency : 3 cycles per byte after bus grant, plus one release cycle that pulses done.
// Backpressure: busak_n deasserted mid-byte stalls the engine and the byte restarts at RD.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cfg_*                       CPU register port (0 src lo, 1 src hi, 2 len lo,
//                               3 {start, -, bank, len[8]}), reads are combinational
//   busrq_n / busak_n           Z80 bus request / acknowledge
//   mem_addr, mem_rdn, mem_din  source read port, data valid the cycle after mem_rdn low
//   obj_addr, obj_wrn, obj_dout object RAM write port
//   done                        one-cycle completion pulse
module sprite_dma (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_wrn,
    input  logic        cfg_rdn,
    input  logic        cfg_ena,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_din,
    output logic [7:0]  cfg_dout,
    output logic        busrq_n,
    input  logic        busak_n,
    output logic [15:0] mem_addr,
    output logic        mem_rdn,
    input  logic [7:0]  mem_din,
    output logic [9:0]  obj_addr,
    output logic        obj_wrn,
    output logic [7:0]  obj_dout,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_CAP, S_WR, S_REL
    } state_t;

    state_t state, state_nxt;

    logic [15:0] src_reg;
    logic [8:0]  len_reg;
    logic        bank_reg;

    logic [15:0] src_cur;
    logic [8:0]  dst_cur;
    logic [8:0]  count;
    logic [7:0]  data_q;
    logic [15:0] mem_addr_q;
    logic [9:0]  obj_addr_q;
    logic        busy;

    // Bits 6..2 of register 3 carry no function.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_din[6:2];

    logic       granted;
    logic       cfg_wr;
    logic       start;
    logic [8:0] start_len;
    logic       advance;
    logic [15:0] src_inc;

    assign granted   = ~busak_n;
    // Register writes are only accepted while idle so a running transfer cannot be disturbed.
    assign cfg_wr    = cfg_ena & ~cfg_wrn & (state == S_IDLE);
    assign start     = cfg_wr & (cfg_addr == 2'd3) & cfg_din[7];
    // The start write also carries len[8], so use the incoming bit, not the stored one.
    assign start_len = {cfg_din[0], len_reg[7:0]};
    assign advance   = (state == S_WR) & granted;
    assign src_inc   = src_cur + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. Losing the grant during RD/CAP/WR parks the engine in RD,
    // so the interrupted byte is fetched again from the same address.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (start_len != 9'd0) ? S_REQ : S_REL;
            S_REQ:  if (granted) state_nxt = S_RD;
            S_RD:   state_nxt = granted ? S_CAP : S_RD;
            S_CAP:  state_nxt = granted ? S_WR : S_RD;
            S_WR:   if (!granted)          state_nxt = S_RD;
                    else if (count == 9'd1) state_nxt = S_REL;
                    else                   state_nxt = S_RD;
            S_REL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; strobes are gated by the grant so a stalled engine stays quiet.
    always_comb begin
        busrq_n = 1'b1;
        mem_rdn = 1'b1;
        obj_wrn = 1'b1;
        done    = 1'b0;
        busy    = 1'b0;
        case (state)
            S_REQ: begin busrq_n = 1'b0; busy = 1'b1; end
            S_RD, S_CAP: begin
                busrq_n = 1'b0;
                busy    = 1'b1;
                mem_rdn = ~granted;
            end
            S_WR: begin
                busrq_n = 1'b0;
                busy    = 1'b1;
                obj_wrn = ~granted;
            end
            S_REL: done = 1'b1;
            default: ;
        endcase
    end

    // Config registers and transfer datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_reg    <= 16'd0;
            len_reg    <= 9'd0;
            bank_reg   <= 1'b0;
            src_cur    <= 16'd0;
            dst_cur    <= 9'd0;
            count      <= 9'd0;
            data_q     <= 8'd0;
            mem_addr_q <= 16'd0;
            obj_addr_q <= 10'd0;
        end else begin
            if (cfg_wr) begin
                case (cfg_addr)
                    2'd0: src_reg[7:0]  <= cfg_din;
                    2'd1: src_reg[15:8] <= cfg_din;
                    2'd2: len_reg[7:0]  <= cfg_din;
                    default: begin
                        bank_reg   <= cfg_din[1];
                        len_reg[8] <= cfg_din[0];
                    end
                endcase
            end
            if (start) begin
                src_cur <= src_reg;
                dst_cur <= 9'd0;
                count   <= start_len;
            end
            if (advance) begin
                src_cur <= src_inc;
                dst_cur <= dst_cur + 9'd1;
                count   <= count - 9'd1;
            end
            // Address register only moves when a read is about to be issued, so it
            // holds its last value the rest of the time.
            if (state_nxt == S_RD)
                mem_addr_q <= advance ? src_inc : src_cur;
            if ((state == S_CAP) && granted) begin
                data_q     <= mem_din;
                obj_addr_q <= {bank_reg, dst_cur};
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign obj_addr = obj_addr_q;
    assign obj_dout = data_q;

    always_comb begin
        cfg_dout = 8'd0;
        if (cfg_ena && !cfg_rdn) begin
            case (cfg_addr)
                2'd0:    cfg_dout = src_reg[7:0];
                2'd1:    cfg_dout = src_reg[15:8];
                2'd2:    cfg_dout = len_reg[7:0];
                default: cfg_dout = {busy, 5'b0, bank_reg, len_reg[8]};
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_dma.sv
module tb_sprite_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wrn = 1'b1;
    logic        cfg_rdn = 1'b1;
    logic        cfg_ena = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [7:0]  cfg_din = 8'd0;
    logic [7:0]  cfg_dout;
    logic        busrq_n;
    logic        busak_n = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rdn;
    logic [7:0]  mem_din = 8'd0;
    logic [9:0]  obj_addr;
    logic        obj_wrn;
    logic [7:0]  obj_dout;
    logic        done;

    always #5 clk = ~clk;

    sprite_dma dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wrn(cfg_wrn), .cfg_rdn(cfg_rdn), .cfg_ena(cfg_ena),
        .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
        .busrq_n(busrq_n), .busak_n(busak_n),
        .mem_addr(mem_addr), .mem_rdn(mem_rdn), .mem_din(mem_din),
        .obj_addr(obj_addr), .obj_wrn(obj_wrn), .obj_dout(obj_dout),
        .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] wq[$];   // expected {obj_addr, data}
    logic [15:0] rq[$];   // expected read addresses
    logic [17:0] wexp;
    logic [15:0] rexp;
    bit   chk_rd   = 1'b0;
    bit   hold_off = 1'b0;
    bit   saw_rq   = 1'b0;
    int   n_wr = 0, n_done = 0, n_rq_cyc = 0;
    logic prev_rdn = 1'b1;
    logic [1:0] gcnt = 2'd0;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source memory: data appears the cycle after the read strobe.
    always @(posedge clk) if (!mem_rdn) mem_din <= mem_val(mem_addr);

    // Bus arbiter: grants two cycles after the request; hold_off withdraws the grant.
    always @(posedge clk) begin
        if (busrq_n) begin
            gcnt    <= 2'd0;
            busak_n <= 1'b1;
        end else if (hold_off) begin
            busak_n <= 1'b1;
        end else if (gcnt == 2'd1) begin
            busak_n <= 1'b0;
        end else begin
            gcnt <= gcnt + 2'd1;
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (!obj_wrn) begin
            n_wr++;
            n_cmp++;
            assert (wq.size() != 0) else begin
                n_err++;
                $error("FAIL extra_write: observed write %0h:%0h expected none", obj_addr, obj_dout);
            end
            if (wq.size() != 0) begin
                wexp = wq.pop_front();
                check("obj_write", 32'({obj_addr, obj_dout}), 32'(wexp));
            end
        end
        if (done) n_done++;
        if (!busrq_n) begin
            saw_rq = 1'b1;
            n_rq_cyc++;
        end
        if (chk_rd && !mem_rdn && prev_rdn) begin
            n_cmp++;
            assert (rq.size() != 0) else begin
                n_err++;
                $error("FAIL extra_read: observed read %0h expected none", mem_addr);
            end
            if (rq.size() != 0) begin
                rexp = rq.pop_front();
                check("read_addr", 32'(mem_addr), 32'(rexp));
            end
        end
        prev_rdn = mem_rdn;
    end

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_ena = 1'b1; cfg_wrn = 1'b0; cfg_addr = a; cfg_din = d;
        @(negedge clk);
        cfg_ena = 1'b0; cfg_wrn = 1'b1;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cfg_ena = 1'b1; cfg_rdn = 1'b0; cfg_addr = a;
        #2;
        d = cfg_dout;
        cfg_ena = 1'b0; cfg_rdn = 1'b1;
    endtask

    task automatic push_xfer(input logic [15:0] src, input int len, input logic bank);
        for (int i = 0; i < len; i++) begin
            logic [15:0] a;
            a = src + 16'(i);
            wq.push_back({bank, 9'(i), mem_val(a)});
        end
    endtask

    task automatic start_xfer(input logic [15:0] src, input logic [8:0] len, input logic bank);
        cfg_write(2'd0, src[7:0]);
        cfg_write(2'd1, src[15:8]);
        cfg_write(2'd2, len[7:0]);
        cfg_write(2'd3, {1'b1, 5'b0, bank, len[8]});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        int i;
        d0 = n_done;
        i  = 0;
        while (n_done == d0 && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        check(tag, 32'(n_done > d0), 32'd1);
    endtask

    task automatic wait_writes(input int target, input string tag);
        int i;
        i = 0;
        while (n_wr < target && i < 1000) begin
            @(negedge clk); #1;
            i++;
        end
        check(tag, 32'(n_wr), 32'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, base;
        logic [7:0] rd;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busrq_n", 32'(busrq_n), 32'd1);
        check("rst_mem_rdn", 32'(mem_rdn), 32'd1);
        check("rst_obj_wrn", 32'(obj_wrn), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_obj_addr", 32'(obj_addr), 32'd0);
        check("rst_obj_dout", 32'(obj_dout), 32'd0);
        check("rst_cfg_dout", 32'(cfg_dout), 32'd0);
        rst_n = 1'b1;
        cfg_read(2'd3, rd);
        check("rst_reg3", 32'(rd), 32'd0);

        // Long transfer into bank 1, crossing len[8]
        d0 = n_done; r0 = n_rq_cyc; base = n_wr;
        push_xfer(16'h6900, 384, 1'b1);
        start_xfer(16'h6900, 9'h180, 1'b1);
        wait_done(1300, "t35_done");
        repeat (3) @(negedge clk);
        #1;
        check("t35_writes", 32'(n_wr - base), 32'd384);
        check("t35_queue_left", 32'(wq.size()), 32'd0);
        check("t35_done_count", 32'(n_done - d0), 32'd1);
        check("t35_busrq_after", 32'(busrq_n), 32'd1);
        check("t35_busrq_cycles", 32'(n_rq_cyc - r0), 32'd1155);

        // Source address wrap
        chk_rd = 1'b1;
        r0 = n_rq_cyc; base = n_wr;
        rq.push_back(16'hFFFE); rq.push_back(16'hFFFF);
        rq.push_back(16'h0000); rq.push_back(16'h0001);
        push_xfer(16'hFFFE, 4, 1'b0);
        start_xfer(16'hFFFE, 9'd4, 1'b0);
        wait_done(100, "t36_done");
        repeat (2) @(negedge clk);
        #1;
        check("t36_writes", 32'(n_wr - base), 32'd4);
        check("t36_reads_left", 32'(rq.size()), 32'd0);
        check("t36_busrq_cycles", 32'(n_rq_cyc - r0), 32'd15);

        // Grant withdrawn during byte 5: strobes idle, byte re-read, nothing duplicated
        base = n_wr; d0 = n_done;
        for (int i = 0; i < 16; i++) begin
            rq.push_back(16'h3000 + 16'(i));
            if (i == 5) rq.push_back(16'h3005);
        end
        push_xfer(16'h3000, 16, 1'b0);
        start_xfer(16'h3000, 9'd16, 1'b0);
        wait_writes(base + 5, "t38_reach_byte5");
        @(negedge clk); #1;
        check("t38_rd5_strobe", 32'(mem_rdn), 32'd0);
        hold_off = 1'b1;
        @(negedge clk); #1;
        check("t38_hold_mem_rdn", 32'(mem_rdn), 32'd1);
        check("t38_hold_busrq_n", 32'(busrq_n), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("t38_hold_obj_wrn", 32'(obj_wrn), 32'd1);
        check("t38_hold_mem_rdn2", 32'(mem_rdn), 32'd1);
        check("t38_hold_no_write", 32'(n_wr - base), 32'd5);
        repeat (3) @(negedge clk);
        hold_off = 1'b0;
        wait_done(200, "t38_done");
        repeat (2) @(negedge clk);
        #1;
        check("t38_writes", 32'(n_wr - base), 32'd16);
        check("t38_queue_left", 32'(wq.size()), 32'd0);
        check("t38_reads_left", 32'(rq.size()), 32'd0);
        check("t38_done_count", 32'(n_done - d0), 32'd1);
        chk_rd = 1'b0;

        // Register writes during a transfer are ignored
        push_xfer(16'h4000, 8, 1'b0);
        start_xfer(16'h4000, 9'd8, 1'b0);
        cfg_write(2'd0, 8'h34);
        cfg_write(2'd1, 8'h12);
        cfg_write(2'd2, 8'h55);
        cfg_read(2'd3, rd);
        check("t39_busy_read", 32'(rd), 32'h80);
        wait_done(200, "t39_done");
        check("t39_queue_left", 32'(wq.size()), 32'd0);
        cfg_read(2'd0, rd); check("t39_reg0", 32'(rd), 32'h00);
        cfg_read(2'd1, rd); check("t39_reg1", 32'(rd), 32'h40);
        cfg_read(2'd2, rd); check("t39_reg2", 32'(rd), 32'h08);
        cfg_read(2'd3, rd); check("t39_reg3", 32'(rd), 32'h00);

        // Zero-length start
        cfg_write(2'd2, 8'h00);
        saw_rq = 1'b0; d0 = n_done;
        cfg_write(2'd3, 8'h80);
        #1;
        check("t37_done_pulse", 32'(done), 32'd1);
        @(negedge clk); #1;
        check("t37_done_low", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("t37_no_busrq", 32'(saw_rq), 32'd0);
        check("t37_done_count", 32'(n_done - d0), 32'd1);

        // Reset mid-transfer
        base = n_wr;
        push_xfer(16'h2000, 100, 1'b1);
        start_xfer(16'h2000, 9'd100, 1'b1);
        wait_writes(base + 3, "t40_reach");
        @(negedge clk);
        rst_n = 1'b0;
        d0 = n_done;
        @(negedge clk); #1;
        check("t40_busrq_n", 32'(busrq_n), 32'd1);
        check("t40_mem_rdn", 32'(mem_rdn), 32'd1);
        check("t40_obj_wrn", 32'(obj_wrn), 32'd1);
        check("t40_mem_addr", 32'(mem_addr), 32'd0);
        check("t40_obj_addr", 32'(obj_addr), 32'd0);
        cfg_read(2'd3, rd);
        check("t40_reg3", 32'(rd), 32'd0);
        wq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("t40_no_done", 32'(n_done - d0), 32'd0);
        check("t40_busrq_idle", 32'(busrq_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_dma.md
SPRITE_DMA -- requirements
Module: sprite_dma

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: cfg_wrn  in  1  CPU register write strobe, active-low.
REQ-004 SHALL have port: cfg_rdn  in  1  CPU register read strobe, active-low.
REQ-005 SHALL have port: cfg_ena  in  1  register-space select.
REQ-006 SHALL have port: cfg_addr  in  2  register index.
REQ-007 SHALL have port: cfg_din  in  8  register write data.
REQ-008 SHALL have port: cfg_dout  out  8  register read data.
REQ-009 SHALL have port: busrq_n  out  1  Z80 bus request, active-low.
REQ-010 SHALL have port: busak_n  in  1  Z80 bus acknowledge, active-low.
REQ-011 SHALL have port: mem_addr  out  16  source read address.
REQ-012 SHALL have port: mem_rdn  out  1  source read strobe, active-low.
REQ-013 SHALL have port: mem_din  in  8  source read data, valid the cycle after mem_rdn low.
REQ-014 SHALL have ports: obj_addr  out  10  objram address; obj_wrn  out  1  objram write strobe, active-low; obj_dout  out  8  objram write data.
REQ-015 SHALL have port: done  out  1  one-cycle completion pulse.

Function
REQ-016 Registers: 0 = src[7:0]; 1 = src[15:8]; 2 = len[7:0]; 3 = {start[7], bank[1], len[8] in bit 0}; a write is a cfg_ena & ~cfg_wrn cycle.
REQ-017 Register writes while busy SHALL be ignored.
REQ-018 Reads: register 3 returns {busy, 5'b0, bank, len[8]}; registers 0-2 return stored values; cfg_dout = 0 when ~cfg_ena or cfg_rdn high.
REQ-019 States: IDLE, REQ, RD, CAP, WR, REL.
REQ-020 IDLE: a write to register 3 with bit 7 = 1 and len != 0 SHALL enter REQ and set busy.
REQ-021 IDLE: start with len = 0 SHALL pulse done the next cycle without asserting busrq_n.
REQ-022 REQ: busrq_n low; wait for busak_n low, then enter RD.
REQ-023 RD: mem_addr = src_cur, mem_rdn low; next cycle is CAP.
REQ-024 CAP: mem_rdn low; latch mem_din into a data register.
REQ-025 WR: obj_addr = {bank, dst_cur[8:0]}, obj_dout = latched data, obj_wrn low for exactly one cycle.
REQ-026 After WR: src_cur+1 (16-bit wrap FFFF->0000), dst_cur+1 (9-bit wrap 1FF->000, bank bit unchanged), count-1; count = 0 enters REL, otherwise RD.
REQ-027 Throughput SHALL be 3 cycles per byte.
REQ-028 REL: busrq_n high, pulse done, clear busy, return to IDLE; total = 3*len + handshake cycles + 1.
REQ-029 The transfer SHALL start at src = reg 0/1, dst_cur = 0, count = len.
REQ-030 busak_n high during RD/CAP/WR SHALL freeze the FSM, deassert mem_rdn and obj_wrn, and hold busrq_n low; the interrupted byte SHALL restart at RD when busak_n returns low.
REQ-031 The transfer SHALL never skip or duplicate a byte.
REQ-032 Outside RD/CAP, mem_rdn SHALL be high; outside WR, obj_wrn SHALL be high; mem_addr and obj_addr SHALL hold their last values.

Reset
REQ-033 rst_n low: state IDLE; busy 0; all registers 0; busrq_n, mem_rdn, obj_wrn high; done 0; mem_addr, obj_addr, obj_dout, cfg_dout 0.
REQ-034 Reset mid-transfer SHALL release the bus on the next edge; the partial transfer is abandoned with no done pulse.

Verification
REQ-035 src=0x6900, len=0x180, bank=1, busak_n low 2 cycles after busrq_n -> 384 writes obj_addr 0x200..0x37F, data match source, done once, busrq_n high after.
REQ-036 src=0xFFFE, len=4 -> reads FFFE, FFFF, 0000, 0001.
REQ-037 start with len=0 -> done one cycle later, busrq_n never low.
REQ-038 busak_n raised 10 cycles in during byte 5 -> strobes idle, byte 5 re-read after regrant, 16 writes total, no duplicates.
REQ-039 Register writes while busy (src=0x1234) -> ignored; reg 3 read shows busy=1; after done, reads return the original values.
REQ-040 rst_n low mid-transfer -> busrq_n high next edge, busy 0, no done pulse.
